pipeline_control: RTL and testbench
===================================

# pipeline_control

Pipelined control unit for the five-stage MIPS core. It decodes the ID-stage opcode/function into a control word and carries the EX, MEM and WB slices forward through registered ID/EX, EX/MEM and MEM/WB stages. It detects load-use hazards, flushes on taken branches and jumps, and freezes on memory wait. The datapath consumes the stage-aligned outputs directly; PC and IF/ID use the hold/flush outputs.

## Interface
- REG_ADDR_W, 5, register-address width
- ALUOP_W, 3, ALUOp width (must be ≥3)
- LINK_REG, 31, destination for JAL
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all stage registers
- OP  in  6  ID-stage opcode
- Function  in  6  ID-stage function field
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  ID-stage register fields
- ex_redirect  in  1  EX stage resolved a taken branch, J, JAL or JR
- mem_ready  in  1  data memory can complete this cycle
- ex_ctrl  out  7+ALUOP_W  {RegisterOrPC, JumpControl, ShamtSelector, RegDst, ALUSrc, BranchNE, BranchEQ, ALUOp}
- mem_ctrl  out  2  {MemRead, MemWrite}
- wb_ctrl  out  3  {ALUMemOrPC, MemtoReg, RegWrite}
- ex_dst, mem_dst, wb_dst  out  REG_ADDR_W each  write destination per stage
- pc_hold, if_id_hold, if_id_flush  out  1 each

## Operation
- ID decode is combinational. Any field not listed below is 0.
  - OP 0x00 with Function 0x00 or 0x02: RegDst, ShamtSelector, RegWrite; ALUOp 7.
  - OP 0x00 with Function 0x08 (JR): RegisterOrPC.
  - OP 0x00 with any other Function: RegDst, RegWrite; ALUOp 7.
  - ADDI (0x08), ORI (0x0d), LUI (0x0f): ALUSrc, RegWrite; ALUOp 4, 5 and 6 respectively.
  - LW (0x23): ALUSrc, MemtoReg, RegWrite, MemRead; ALUOp 4.
  - SW (0x2b): ALUSrc, MemWrite; ALUOp 4.
  - J (0x02): JumpControl.
  - JAL (0x03): JumpControl, ALUMemOrPC, RegWrite.
  - BEQ (0x04) / BNE (0x05): BranchEQ / BranchNE; ALUOp 3.
  - Any other opcode: all-zero word (bubble).
- ALUOp is zero-extended to ALUOP_W.
- Destination is computed in ID and is 0 when RegWrite=0:
  - JAL: LINK_REG.
  - RegDst=1: id_rd.
  - Otherwise: id_rt.
- Load-use stall (load_use) asserts when all of the following hold:
  - ID/EX MemRead=1;
  - ex_dst≠0;
  - ex_dst equals id_rs or id_rt.
- Per-cycle action, first match wins:
  1. mem_ready=0: all three stage registers hold; pc_hold=1, if_id_hold=1, if_id_flush=0.
  2. ex_redirect=1: ID/EX loads a bubble; EX/MEM and MEM/WB advance; if_id_flush=1, pc_hold=0, if_id_hold=0.
  3. load_use=1: ID/EX loads a bubble; EX/MEM and MEM/WB advance; pc_hold=1, if_id_hold=1.
  4. Otherwise: all stages advance; ID/EX loads the decoded word.
- A bubble is the all-zero control word with dst=0. It must never write a register or memory.
- The instruction in EX when ex_redirect fires still advances to MEM, so JAL's link write completes.

## Timing
- Reset (async assert): all outputs 0. pc_hold, if_id_hold and if_id_flush are 0 while reset is low.
- Reset release is synchronous to clk; the first decode is captured on the first rising edge after release.
- Latency: decoded control reaches ex_ctrl 1 cycle after ID, mem_ctrl after 2, wb_ctrl after 3.
- hold/flush outputs are combinational from the current cycle's inputs and stage state.
- load_use lasts exactly one cycle per load. After the bubble, ID/EX MemRead=0.
- Simultaneous ex_redirect and load_use: the flush wins and no hold is asserted.
- Memory wait takes precedence over both.
- Reset asserted mid-stall clears everything; there is no resume state.

## Structure
- Package pipeline_ctrl_pkg holds:
  - opcode and function localparams;
  - ALUOp codes;
  - field bit-index constants for the ex/mem/wb words;
  - the bubble constant.
- Sub-module ctrl_decode: the combinational OP/Function to control word and dst decode.
- The top module holds the three stage registers, the hazard detect and the priority logic.

## Test plan
- Reset low with random inputs → all outputs 0. Release, then ADDI (OP 0x08, rt=5) → ex_ctrl ALUSrc=1, ALUOp=4, ex_dst=5 one cycle later; wb_ctrl RegWrite=1, wb_dst=5 three cycles after ID.
- LW rt=8, then ADD rs=8 → one cycle pc_hold=if_id_hold=1, bubble in EX, then ADD proceeds. Same test with rt=0 → no stall.
- BEQ in EX with ex_redirect=1 while LW-dependent instruction in ID → if_id_flush=1, no hold, ex_ctrl=0 next cycle.
- JAL → wb_ctrl={1,0,1}, wb_dst=31 three cycles after ID despite the redirect flushing the younger instruction.
- mem_ready=0 for 3 cycles during SW in MEM → mem_ctrl MemWrite stays 1 and all stage outputs stay frozen; on mem_ready=1 they advance by one stage.
- Undefined OP 0x3f and JR (Function 0x08) → all-zero word, and RegisterOrPC=1 only, respectively; dst=0 for both.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package pipeline_ctrl_pkg;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // Function codes for OP_RTYPE
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;

   // ALUOp codes (native 3 bits, zero-extended by the top)
   localparam logic [2:0] ALU_NONE  = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd3;
   localparam logic [2:0] ALU_ADD   = 3'd4;
   localparam logic [2:0] ALU_OR    = 3'd5;
   localparam logic [2:0] ALU_LUI   = 3'd6;
   localparam logic [2:0] ALU_RTYPE = 3'd7;

   // EX flag indices, counted from the bit just above the ALUOp field
   localparam int EX_BEQ    = 0;
   localparam int EX_BNE    = 1;
   localparam int EX_ALUSRC = 2;
   localparam int EX_REGDST = 3;
   localparam int EX_SHAMT  = 4;
   localparam int EX_JUMP   = 5;
   localparam int EX_REGPC  = 6;

   // MEM word indices
   localparam int MEM_WRITE = 0;
   localparam int MEM_READ  = 1;

   // WB word indices
   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;
   localparam int WB_ALUMEMPC = 2;

   typedef struct packed {
      logic [6:0] ex_flags;
      logic [2:0] alu_op;
      logic [1:0] mem;
      logic [2:0] wb;
   } ctrl_word_t;

   // Bubble: no register, memory or control-flow side effects
   localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ID-stage decode of OP/Function into a control word and write destination.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is captured.
module ctrl_decode
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int LINK_REG   = 31
) (
   input  logic [5:0]            op,
   input  logic [5:0]            funct,
   input  logic [REG_ADDR_W-1:0] rt,
   input  logic [REG_ADDR_W-1:0] rd,
   output ctrl_word_t            word,
   output logic [REG_ADDR_W-1:0] dst
);

   localparam logic [REG_ADDR_W-1:0] LINK = REG_ADDR_W'(LINK_REG);

   // Opcode/function to control word; unknown opcodes fall through as a bubble
   always_comb begin
      word = CTRL_BUBBLE;
      case (op)
         OP_RTYPE: begin
            if (funct == FN_JR) begin
               word.ex_flags[EX_REGPC] = 1'b1;
            end else begin
               word.ex_flags[EX_REGDST] = 1'b1;
               word.wb[WB_REGWRITE]     = 1'b1;
               word.alu_op              = ALU_RTYPE;
               if (funct == FN_SLL || funct == FN_SRL)
                  word.ex_flags[EX_SHAMT] = 1'b1;
            end
         end
         OP_ADDI, OP_ORI, OP_LUI: begin
            word.ex_flags[EX_ALUSRC] = 1'b1;
            word.wb[WB_REGWRITE]     = 1'b1;
            word.alu_op = (op == OP_ADDI) ? ALU_ADD :
                          (op == OP_ORI)  ? ALU_OR  : ALU_LUI;
         end
         OP_LW: begin
            word.ex_flags[EX_ALUSRC] = 1'b1;
            word.wb[WB_MEMTOREG]     = 1'b1;
            word.wb[WB_REGWRITE]     = 1'b1;
            word.mem[MEM_READ]       = 1'b1;
            word.alu_op              = ALU_ADD;
         end
         OP_SW: begin
            word.ex_flags[EX_ALUSRC] = 1'b1;
            word.mem[MEM_WRITE]      = 1'b1;
            word.alu_op              = ALU_ADD;
         end
         OP_J: begin
            word.ex_flags[EX_JUMP] = 1'b1;
         end
         OP_JAL: begin
            word.ex_flags[EX_JUMP] = 1'b1;
            word.wb[WB_ALUMEMPC]   = 1'b1;
            word.wb[WB_REGWRITE]   = 1'b1;
         end
         OP_BEQ: begin
            word.ex_flags[EX_BEQ] = 1'b1;
            word.alu_op           = ALU_SUB;
         end
         OP_BNE: begin
            word.ex_flags[EX_BNE] = 1'b1;
            word.alu_op           = ALU_SUB;
         end
         default: word = CTRL_BUBBLE;
      endcase
   end

   // Destination register; forced to 0 for non-writing instructions
   always_comb begin
      if (!word.wb[WB_REGWRITE])
         dst = '0;
      else if (op == OP_JAL)
         dst = LINK;
      else if (word.ex_flags[EX_REGDST])
         dst = rd;
      else
         dst = rt;
   end

endmodule

// File: rtl/pipeline_control.sv
// Pipelined control: ID decode carried through ID/EX, EX/MEM, MEM/WB with hazard handling.
// Latency: ex_ctrl 1 cycle after ID, mem_ctrl 2, wb_ctrl 3; hold/flush are combinational.
// Backpressure: mem_ready=0 freezes all stages; load-use inserts one bubble; redirect flushes ID.
module pipeline_control
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 3,
   parameter int LINK_REG   = 31
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             OP,
   input  logic [5:0]             Function,
   input  logic [REG_ADDR_W-1:0]  id_rs,
   input  logic [REG_ADDR_W-1:0]  id_rt,
   input  logic [REG_ADDR_W-1:0]  id_rd,
   input  logic                   ex_redirect,
   input  logic                   mem_ready,
   output logic [7+ALUOP_W-1:0]   ex_ctrl,
   output logic [1:0]             mem_ctrl,
   output logic [2:0]             wb_ctrl,
   output logic [REG_ADDR_W-1:0]  ex_dst,
   output logic [REG_ADDR_W-1:0]  mem_dst,
   output logic [REG_ADDR_W-1:0]  wb_dst,
   output logic                   pc_hold,
   output logic                   if_id_hold,
   output logic                   if_id_flush
);

   ctrl_word_t            dec_word;
   logic [REG_ADDR_W-1:0] dec_dst;
   logic [7+ALUOP_W-1:0]  dec_ex;

   // ID/EX
   logic [7+ALUOP_W-1:0]  idex_ex;
   logic [1:0]            idex_mem;
   logic [2:0]            idex_wb;
   logic [REG_ADDR_W-1:0] idex_dst;
   // EX/MEM
   logic [1:0]            exmem_mem;
   logic [2:0]            exmem_wb;
   logic [REG_ADDR_W-1:0] exmem_dst;
   // MEM/WB
   logic [2:0]            memwb_wb;
   logic [REG_ADDR_W-1:0] memwb_dst;

   logic load_use;
   logic idex_bubble;

   ctrl_decode #(
      .REG_ADDR_W (REG_ADDR_W),
      .LINK_REG   (LINK_REG)
   ) u_decode (
      .op    (OP),
      .funct (Function),
      .rt    (id_rt),
      .rd    (id_rd),
      .word  (dec_word),
      .dst   (dec_dst)
   );

   assign dec_ex = {dec_word.ex_flags, ALUOP_W'(dec_word.alu_op)};

   // Load in EX whose nonzero destination feeds the instruction in ID
   assign load_use = idex_mem[MEM_READ] && (idex_dst != '0) &&
                     ((idex_dst == id_rs) || (idex_dst == id_rt));

   assign idex_bubble = ex_redirect || load_use;

   // Hold/flush priority: memory wait, then redirect, then load-use; quiet in reset
   always_comb begin
      pc_hold     = 1'b0;
      if_id_hold  = 1'b0;
      if_id_flush = 1'b0;
      if (reset) begin
         if (!mem_ready) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
         end else if (ex_redirect) begin
            if_id_flush = 1'b1;
         end else if (load_use) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
         end
      end
   end

   // Stage registers: freeze on memory wait, otherwise advance with optional ID/EX bubble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idex_ex   <= '0;
         idex_mem  <= '0;
         idex_wb   <= '0;
         idex_dst  <= '0;
         exmem_mem <= '0;
         exmem_wb  <= '0;
         exmem_dst <= '0;
         memwb_wb  <= '0;
         memwb_dst <= '0;
      end else if (mem_ready) begin
         memwb_wb  <= exmem_wb;
         memwb_dst <= exmem_dst;
         exmem_mem <= idex_mem;
         exmem_wb  <= idex_wb;
         exmem_dst <= idex_dst;
         if (idex_bubble) begin
            idex_ex  <= '0;
            idex_mem <= '0;
            idex_wb  <= '0;
            idex_dst <= '0;
         end else begin
            idex_ex  <= dec_ex;
            idex_mem <= dec_word.mem;
            idex_wb  <= dec_word.wb;
            idex_dst <= dec_dst;
         end
      end
   end

   assign ex_ctrl  = idex_ex;
   assign ex_dst   = idex_dst;
   assign mem_ctrl = exmem_mem;
   assign mem_dst  = exmem_dst;
   assign wb_ctrl  = memwb_wb;
   assign wb_dst   = memwb_dst;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control with hand-computed control words.
// Inputs change 1 ns after the rising edge; outputs are checked at that point.
// ex_ctrl bit map (ALUOP_W=3): 9 RegPC, 8 Jump, 7 Shamt, 6 RegDst, 5 ALUSrc, 4 BNE, 3 BEQ, 2:0 ALUOp.
module tb_pipeline_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] OP, Function;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       ex_redirect, mem_ready;
   logic [9:0] ex_ctrl;
   logic [1:0] mem_ctrl;
   logic [2:0] wb_ctrl;
   logic [4:0] ex_dst, mem_dst, wb_dst;
   logic       pc_hold, if_id_hold, if_id_flush;

   int tests = 0;
   int fails = 0;

   pipeline_control #(.REG_ADDR_W(5), .ALUOP_W(3), .LINK_REG(31)) dut (
      .clk         (clk),
      .reset       (reset),
      .OP          (OP),
      .Function    (Function),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .ex_redirect (ex_redirect),
      .mem_ready   (mem_ready),
      .ex_ctrl     (ex_ctrl),
      .mem_ctrl    (mem_ctrl),
      .wb_ctrl     (wb_ctrl),
      .ex_dst      (ex_dst),
      .mem_dst     (mem_dst),
      .wb_dst      (wb_dst),
      .pc_hold     (pc_hold),
      .if_id_hold  (if_id_hold),
      .if_id_flush (if_id_flush)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      OP = op; Function = fn; id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   // Undefined opcode used as a harmless filler instruction
   task automatic set_filler;
      set_id(6'h3f, 6'h00, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         OP = 6'($urandom); Function = 6'($urandom);
         id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
         ex_redirect = 1'($urandom); mem_ready = 1'($urandom);
         tick();
         tests++;
         if ({ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst} !== '0 ||
             {pc_hold, if_id_hold, if_id_flush} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outputs iter %0d: ex=%h mem=%h wb=%h dst=%h/%h/%h hold/flush=%b%b%b, want all 0",
                     i, ex_ctrl, mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst, pc_hold, if_id_hold, if_id_flush);
         end
      end
      ex_redirect = 1'b0; mem_ready = 1'b1;
      set_filler();
      reset = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_addi;
      set_id(6'h08, 6'h00, 5'd1, 5'd5, 5'd9);
      tick();
      set_filler();
      tests++;
      if (ex_ctrl !== 10'h024 || ex_dst !== 5'd5) begin
         fails++;
         $display("FAIL addi_ex: ex_ctrl=%h ex_dst=%0d, want 024/5", ex_ctrl, ex_dst);
      end
      tick();
      tests++;
      if (mem_ctrl !== 2'b00 || mem_dst !== 5'd5) begin
         fails++;
         $display("FAIL addi_mem: mem_ctrl=%b mem_dst=%0d, want 00/5", mem_ctrl, mem_dst);
      end
      tick();
      tests++;
      if (wb_ctrl !== 3'b001 || wb_dst !== 5'd5) begin
         fails++;
         $display("FAIL addi_wb: wb_ctrl=%b wb_dst=%0d, want 001/5", wb_ctrl, wb_dst);
      end
   endtask

   task automatic test_load_use;
      // Dependent ADD after LW rt=8 stalls exactly one cycle
      set_id(6'h23, 6'h00, 5'd1, 5'd8, 5'd0);
      tick();
      set_id(6'h00, 6'h20, 5'd8, 5'd2, 5'd3);
      #1;
      tests++;
      if ({pc_hold, if_id_hold, if_id_flush} !== 3'b110) begin
         fails++;
         $display("FAIL load_use_hold: hold/flush=%b%b%b, want 110", pc_hold, if_id_hold, if_id_flush);
      end
      tick();
      tests++;
      if (ex_ctrl !== 10'h000 || ex_dst !== 5'd0 || mem_ctrl !== 2'b10 || mem_dst !== 5'd8) begin
         fails++;
         $display("FAIL load_use_bubble: ex=%h/%0d mem=%b/%0d, want 000/0 10/8", ex_ctrl, ex_dst, mem_ctrl, mem_dst);
      end
      tests++;
      if ({pc_hold, if_id_hold} !== 2'b00) begin
         fails++;
         $display("FAIL load_use_once: pc_hold=%b if_id_hold=%b, want 00", pc_hold, if_id_hold);
      end
      tick();
      tests++;
      if (ex_ctrl !== 10'h047 || ex_dst !== 5'd3) begin
         fails++;
         $display("FAIL load_use_resume: ex_ctrl=%h ex_dst=%0d, want 047/3", ex_ctrl, ex_dst);
      end
      // LW to $0 never stalls
      set_id(6'h23, 6'h00, 5'd1, 5'd0, 5'd0);
      tick();
      set_id(6'h00, 6'h20, 5'd0, 5'd2, 5'd3);
      #1;
      tests++;
      if ({pc_hold, if_id_hold} !== 2'b00) begin
         fails++;
         $display("FAIL load_use_r0: pc_hold=%b if_id_hold=%b, want 00", pc_hold, if_id_hold);
      end
      tick();
      tests++;
      if (ex_ctrl !== 10'h047) begin
         fails++;
         $display("FAIL load_use_r0_ex: ex_ctrl=%h, want 047", ex_ctrl);
      end
      set_filler();
      tick();
   endtask

   task automatic test_redirect;
      // BEQ reaches EX with its decoded word
      set_id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
      tick();
      tests++;
      if (ex_ctrl !== 10'h00B || ex_dst !== 5'd0) begin
         fails++;
         $display("FAIL beq_ex: ex_ctrl=%h ex_dst=%0d, want 00B/0", ex_ctrl, ex_dst);
      end
      // Redirect together with a load-use condition: flush wins, no hold
      set_id(6'h23, 6'h00, 5'd1, 5'd9, 5'd0);
      tick();
      set_id(6'h00, 6'h20, 5'd9, 5'd2, 5'd3);
      ex_redirect = 1'b1;
      #1;
      tests++;
      if ({pc_hold, if_id_hold, if_id_flush} !== 3'b001) begin
         fails++;
         $display("FAIL redirect_prio: hold/flush=%b%b%b, want 001", pc_hold, if_id_hold, if_id_flush);
      end
      tick();
      ex_redirect = 1'b0;
      set_filler();
      tests++;
      if (ex_ctrl !== 10'h000 || ex_dst !== 5'd0 || mem_ctrl !== 2'b10 || mem_dst !== 5'd9) begin
         fails++;
         $display("FAIL redirect_bubble: ex=%h/%0d mem=%b/%0d, want 000/0 10/9", ex_ctrl, ex_dst, mem_ctrl, mem_dst);
      end
      tick();
   endtask

   task automatic test_jal;
      set_id(6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
      tick();
      tests++;
      if (ex_ctrl !== 10'h100 || ex_dst !== 5'd31) begin
         fails++;
         $display("FAIL jal_ex: ex_ctrl=%h ex_dst=%0d, want 100/31", ex_ctrl, ex_dst);
      end
      set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
      ex_redirect = 1'b1;
      tick();
      ex_redirect = 1'b0;
      set_filler();
      tests++;
      if (ex_ctrl !== 10'h000 || mem_dst !== 5'd31) begin
         fails++;
         $display("FAIL jal_flush: ex_ctrl=%h mem_dst=%0d, want 000/31", ex_ctrl, mem_dst);
      end
      tick();
      tests++;
      if (wb_ctrl !== 3'b101 || wb_dst !== 5'd31) begin
         fails++;
         $display("FAIL jal_wb: wb_ctrl=%b wb_dst=%0d, want 101/31", wb_ctrl, wb_dst);
      end
   endtask

   task automatic test_mem_wait;
      set_id(6'h2b, 6'h00, 5'd1, 5'd4, 5'd0);
      tick();
      set_id(6'h08, 6'h00, 5'd1, 5'd6, 5'd0);
      tick();
      set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd7);
      mem_ready = 1'b0;
      ex_redirect = 1'b1;
      #1;
      tests++;
      if ({pc_hold, if_id_hold, if_id_flush} !== 3'b110) begin
         fails++;
         $display("FAIL mem_wait_prio: hold/flush=%b%b%b, want 110", pc_hold, if_id_hold, if_id_flush);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         ex_redirect = 1'b0;
         tests++;
         if (mem_ctrl !== 2'b01 || mem_dst !== 5'd0 || ex_ctrl !== 10'h024 || ex_dst !== 5'd6) begin
            fails++;
            $display("FAIL mem_wait_frozen cycle %0d: mem=%b/%0d ex=%h/%0d, want 01/0 024/6",
                     i, mem_ctrl, mem_dst, ex_ctrl, ex_dst);
         end
      end
      mem_ready = 1'b1;
      tick();
      set_filler();
      tests++;
      if (mem_ctrl !== 2'b00 || mem_dst !== 5'd6 || wb_ctrl !== 3'b000 || wb_dst !== 5'd0 ||
          ex_ctrl !== 10'h047 || ex_dst !== 5'd7) begin
         fails++;
         $display("FAIL mem_wait_release: ex=%h/%0d mem=%b/%0d wb=%b/%0d, want 047/7 00/6 000/0",
                  ex_ctrl, ex_dst, mem_ctrl, mem_dst, wb_ctrl, wb_dst);
      end
      tick();
   endtask

   task automatic test_decode_table;
      logic [5:0] t_op [8] = '{6'h3f, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h05, 6'h02, 6'h00};
      logic [5:0] t_fn [8] = '{6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02};
      logic [9:0] t_ex [8] = '{10'h000, 10'h200, 10'h0C7, 10'h025, 10'h026, 10'h013, 10'h100, 10'h0C7};
      logic [4:0] t_ds [8] = '{5'd0, 5'd0, 5'd11, 5'd10, 5'd10, 5'd0, 5'd0, 5'd11};
      for (int i = 0; i < 8; i++) begin
         set_id(t_op[i], t_fn[i], 5'd12, 5'd10, 5'd11);
         tick();
         tests++;
         if (ex_ctrl !== t_ex[i] || ex_dst !== t_ds[i]) begin
            fails++;
            $display("FAIL decode[%0d] op=%h fn=%h: ex_ctrl=%h ex_dst=%0d, want %h/%0d",
                     i, t_op[i], t_fn[i], ex_ctrl, ex_dst, t_ex[i], t_ds[i]);
         end
      end
      set_filler();
      tick();
   endtask

   task automatic test_reset_mid_stall;
      set_id(6'h23, 6'h00, 5'd1, 5'd8, 5'd0);
      tick();
      set_id(6'h00, 6'h20, 5'd8, 5'd2, 5'd3);
      reset = 1'b0;
      #1;
      tests++;
      if (ex_ctrl !== '0 || ex_dst !== '0 || mem_ctrl !== '0 ||
          {pc_hold, if_id_hold, if_id_flush} !== 3'b000) begin
         fails++;
         $display("FAIL reset_mid_stall: ex=%h/%0d mem=%b hold/flush=%b%b%b, want all 0",
                  ex_ctrl, ex_dst, mem_ctrl, pc_hold, if_id_hold, if_id_flush);
      end
      reset = 1'b1;
      tick();
      tests++;
      if (ex_ctrl !== 10'h047 || ex_dst !== 5'd3) begin
         fails++;
         $display("FAIL reset_resume: ex_ctrl=%h ex_dst=%0d, want 047/3", ex_ctrl, ex_dst);
      end
   endtask

   initial begin
      reset = 1'b0;
      ex_redirect = 1'b0;
      mem_ready = 1'b1;
      set_filler();
      test_reset();
      test_addi();
      test_load_use();
      test_redirect();
      test_jal();
      test_mem_wait();
      test_decode_table();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
